// File: rtl/cpu_step_ctrl.sv
// Clock-enable sequencer for the MIPS core: free-run at four rates, debounced single-step, halt.
// Optional breakpoint support is enabled by defining CPU_STEP_BREAKPOINT_EN.
//
// state   | meaning
// HALT    | core stopped; waits for run_sw or a debounced step press
// STEP    | single cpu_en strobe for a button press, then back to HALT
// RUN     | free-run; cpu_en every DIV[div_sel] cycles
module cpu_step_ctrl #(
    parameter int DIV0     = 50_000_000,
    parameter int DIV1     = 12_500_000,
    parameter int DIV2     = 1_250_000,
    parameter int DIV3     = 1,
    parameter int DEBOUNCE = 500_000,
    parameter int CNT_W    = 32
) (
    input  logic        iclk,
    input  logic        reset,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  div_sel,
`ifdef CPU_STEP_BREAKPOINT_EN
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
    output logic        bp_hit,
`endif
    output logic        cpu_en,
    output logic        halted,
    output logic [15:0] step_count
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             db_level_q, db_level_d;
    logic             db_prev_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             step_req;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_last;
    logic             cpu_en_q, cpu_en_d;
    logic             halted_q, halted_d;
    logic [15:0]      step_count_q, step_count_d;
    logic             bp_stop;
    logic             run_ok;

    // Debounced level only follows the synchronized button after DEBOUNCE differing cycles.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_ONE;
            end
        end
    end

    assign step_req = db_level_q & ~db_prev_q;

    always_comb begin
        case (div_sel)
            2'd0:    div_last = CNT_W'(DIV0 - 1);
            2'd1:    div_last = CNT_W'(DIV1 - 1);
            2'd2:    div_last = CNT_W'(DIV2 - 1);
            default: div_last = CNT_W'(DIV3 - 1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_sw && run_ok) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (step_req) begin
                    state_d  = ST_STEP;
                    cpu_en_d = 1'b1;
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_RUN: begin
                // Stop takes priority over a coincident terminal count.
                if (!run_sw) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (cnt_q >= div_last) begin
                    cnt_d = '0;
                    if (bp_stop) begin
                        state_d = ST_HALT;
                    end else begin
                        cpu_en_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end
        endcase
        halted_d     = (state_d != ST_RUN);
        step_count_d = step_count_q + {15'd0, cpu_en_d};
    end

`ifdef CPU_STEP_BREAKPOINT_EN
    logic first_tc_q, first_tc_d;
    logic armed_q, armed_d;
    logic bp_hit_q, bp_hit_d;
    logic run_tc;

    assign run_tc  = (state_q == ST_RUN) && run_sw && (cnt_q >= div_last);
    assign bp_stop = bp_valid && (pc == bp_addr) && !first_tc_q;
    assign run_ok  = armed_q;

    // The first terminal count after entering RUN is exempt so the core can step past a breakpoint.
    always_comb begin
        first_tc_d = first_tc_q;
        armed_d    = armed_q;
        bp_hit_d   = bp_hit_q;
        if (!run_sw) begin
            armed_d = 1'b1;
        end
        if (state_q != ST_RUN && state_d == ST_RUN) begin
            first_tc_d = 1'b1;
            bp_hit_d   = 1'b0;
        end
        if (state_d == ST_STEP) begin
            bp_hit_d = 1'b0;
        end
        if (run_tc) begin
            first_tc_d = 1'b0;
            if (bp_stop) begin
                bp_hit_d = 1'b1;
                armed_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (reset) begin
            first_tc_q <= 1'b1;
            armed_q    <= 1'b1;
            bp_hit_q   <= 1'b0;
        end else begin
            first_tc_q <= first_tc_d;
            armed_q    <= armed_d;
            bp_hit_q   <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_stop = 1'b0;
    assign run_ok  = 1'b1;
`endif

    always_ff @(posedge iclk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= ST_HALT;
            cnt_q        <= '0;
            cpu_en_q     <= 1'b0;
            halted_q     <= 1'b1;
            step_count_q <= '0;
        end else begin
            sync1_q      <= step_btn;
            sync2_q      <= sync1_q;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_level_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cpu_en_q     <= cpu_en_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios plus random run/step/reset traffic
// compared each cycle against a behavioural model of the sequencer.
module tb_cpu_step_ctrl;

    localparam int D0 = 4;
    localparam int D1 = 10;
    localparam int D2 = 3;
    localparam int D3 = 1;
    localparam int DB = 8;

    logic        iclk = 1'b0;
    logic        reset;
    logic        run_sw;
    logic        step_btn;
    logic [1:0]  div_sel;
    logic        cpu_en;
    logic        halted;
    logic [15:0] step_count;
`ifdef CPU_STEP_BREAKPOINT_EN
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        bp_hit;
`endif

    cpu_step_ctrl #(
        .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3), .DEBOUNCE(DB), .CNT_W(32)
    ) dut (
        .iclk(iclk),
        .reset(reset),
        .run_sw(run_sw),
        .step_btn(step_btn),
        .div_sel(div_sel),
`ifdef CPU_STEP_BREAKPOINT_EN
        .pc(pc),
        .bp_addr(bp_addr),
        .bp_valid(bp_valid),
        .bp_hit(bp_hit),
`endif
        .cpu_en(cpu_en),
        .halted(halted),
        .step_count(step_count)
    );

    always #10 iclk = ~iclk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_en  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=halted, 1=single step, 2=running.
    int m_mode;
    int m_phase;      // cycles spent in RUN since entry or last strobe
    int m_count;
    bit m_en;
    bit m_lvl;
    bit m_lvl_prev;
    int m_streak;
    bit btn_q[$];     // button as sampled at the last two edges (oldest first)
    int div_tab[4] = '{D0, D1, D2, D3};

    task automatic model_edge(input bit r, input bit rs, input bit b, input logic [1:0] sel);
        bit req;
        bit seen;
        if (r) begin
            m_mode = 0; m_phase = 0; m_count = 0; m_en = 0;
            m_lvl = 0; m_lvl_prev = 0; m_streak = 0;
            btn_q = '{1'b0, 1'b0};
            return;
        end
        // the debouncer sees the button two edges late (synchronizer)
        seen = btn_q.pop_front();
        btn_q.push_back(b);
        req = m_lvl && !m_lvl_prev;
        m_lvl_prev = m_lvl;
        if (seen != m_lvl) begin
            m_streak++;
            if (m_streak == DB) begin
                m_lvl = seen;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
        m_en = 0;
        case (m_mode)
            0: begin
                if (rs) begin
                    m_mode = 2; m_phase = 0;
                end else if (req) begin
                    m_mode = 1; m_en = 1;
                end
            end
            1: m_mode = 0;
            default: begin
                if (!rs) begin
                    m_mode = 0; m_phase = 0;
                end else if (m_phase + 1 >= div_tab[sel]) begin
                    m_phase = 0; m_en = 1;
                end else begin
                    m_phase++;
                end
            end
        endcase
        m_count = (m_count + int'(m_en)) % 65536;
    endtask

    task automatic tick(input bit r, input bit rs, input bit b, input logic [1:0] sel);
        reset = r; run_sw = rs; step_btn = b; div_sel = sel;
        @(posedge iclk);
        model_edge(r, rs, b, sel);
        @(negedge iclk);
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        chk("halted", {31'd0, halted}, {31'd0, m_mode != 2});
        chk("step_count", {16'd0, step_count}, m_count);
        if (cpu_en) n_en++;
    endtask

`ifdef CPU_STEP_BREAKPOINT_EN
    task automatic raw_cycle(input bit r, input bit rs, input bit b, input logic [1:0] sel);
        reset = r; run_sw = rs; step_btn = b; div_sel = sel;
        @(posedge iclk);
        @(negedge iclk);
        if (cpu_en) n_en++;
    endtask
`endif

    initial begin
        int first_idx;
        bit rs_r, b_r;
        logic [1:0] sel_r;
        int hold;

        reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; div_sel = 2'd0;
`ifdef CPU_STEP_BREAKPOINT_EN
        pc = 32'h0; bp_addr = 32'h0040_0010; bp_valid = 1'b0;
`endif
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_count", {16'd0, step_count}, 32'd0);
        tick(0, 0, 0, 0);

        // free run at DIV0
        n_en = 0; first_idx = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(0, 1, 0, 2'd0);
            if (cpu_en && first_idx < 0) first_idx = i;
        end
        chk("first_strobe_lat", first_idx, 32'd5);
        chk("run_strobes", n_en, 32'd4);
        chk("run_halted", {31'd0, halted}, 32'd0);
        chk("run_count", {16'd0, step_count}, 32'd4);

        // held button gives one strobe; short glitch gives none
        tick(0, 0, 0, 0);
        n_en = 0;
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 0);
        chk("hold_one_strobe", n_en, 32'd1);
        n_en = 0;
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 0);
        chk("glitch_no_strobe", n_en, 32'd0);

        // rate change with an overrun count, then stop on a terminal cycle
        for (int i = 0; i < 7; i++) tick(0, 1, 0, 2'd1);
        tick(0, 1, 0, 2'd0);
        chk("div_switch_strobe", {31'd0, cpu_en}, 32'd1);
        n_en = 0;
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 2'd0);
        chk("gap_after_switch", n_en, 32'd0);
        tick(0, 1, 0, 2'd0);
        chk("period_after_switch", {31'd0, cpu_en}, 32'd1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 2'd0);
        tick(0, 0, 0, 2'd0);
        chk("stop_wins_en", {31'd0, cpu_en}, 32'd0);
        chk("stop_halted", {31'd0, halted}, 32'd1);

        // random traffic against the model
        rs_r = 0; b_r = 0; sel_r = 2'd0; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) rs_r = ~rs_r;
            if ($urandom_range(0, 59) == 0) sel_r = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                b_r = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            tick(($urandom_range(0, 399) == 0), rs_r, b_r, sel_r);
        end

        // wrap of step_count at DIV3
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_en = 0;
        for (int i = 0; i < 70000 && n_en < 65536; i++) tick(0, 1, 0, 2'd3);
        chk("wrap_strobes", n_en, 32'd65536);
        chk("wrap_count", {16'd0, step_count}, 32'd0);
        tick(0, 1, 0, 2'd3);
        tick(1, 1, 0, 2'd3);
        chk("reset_run_en", {31'd0, cpu_en}, 32'd0);
        chk("reset_run_halted", {31'd0, halted}, 32'd1);
        chk("reset_run_count", {16'd0, step_count}, 32'd0);

`ifdef CPU_STEP_BREAKPOINT_EN
        // breakpoint: first terminal count exempt, second suppressed
        pc = 32'h0040_0010; bp_valid = 1'b1;
        raw_cycle(1, 0, 0, 0);
        n_en = 0;
        for (int i = 0; i < 12; i++) raw_cycle(0, 1, 0, 2'd0);
        chk("bp_strobes", n_en, 32'd1);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
        n_en = 0;
        for (int i = 0; i < 3; i++) raw_cycle(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) raw_cycle(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) raw_cycle(0, 0, 0, 0);
        chk("bp_step_strobe", n_en, 32'd1);
        chk("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
        bp_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
